// File: rtl/cpu_pkg.sv
// Shared types and encodings for the controller FSM and instruction decoder.
package cpu_pkg;

    typedef enum logic [2:0] {
        StWait,
        StDecode,
        StWrImm,
        StGetA,
        StGetB,
        StAlu,
        StWrReg
    } state_e;

    typedef enum logic [1:0] {
        NSEL_RN,
        NSEL_RD,
        NSEL_RM
    } nsel_e;

    localparam logic [2:0] OPC_MOV = 3'b110;
    localparam logic [2:0] OPC_ALU = 3'b101;

    localparam logic [1:0] OP_MOV_IMM = 2'b10;
    localparam logic [1:0] OP_MOV_REG = 2'b00;
    localparam logic [1:0] OP_ADD     = 2'b00;
    localparam logic [1:0] OP_CMP     = 2'b01;
    localparam logic [1:0] OP_AND     = 2'b10;
    localparam logic [1:0] OP_MVN     = 2'b11;

    localparam logic [1:0] VSEL_C     = 2'b00;
    localparam logic [1:0] VSEL_PC    = 2'b01;
    localparam logic [1:0] VSEL_IMM   = 2'b10;
    localparam logic [1:0] VSEL_MDATA = 2'b11;

    function automatic logic is_legal(input logic [2:0] opc, input logic [1:0] op);
        return (opc == OPC_ALU) ||
               (opc == OPC_MOV && (op == OP_MOV_IMM || op == OP_MOV_REG));
    endfunction

endpackage

// File: rtl/instr_decoder.sv
// Combinational field extraction, sign extension and register-index mux for the IR.
module instr_decoder
    import cpu_pkg::*;
#(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned RN_W  = 3
) (
    input  logic [WIDTH-1:0] ir,
    input  nsel_e            nsel,
    output logic [2:0]       opcode,
    output logic [1:0]       op,
    output logic [1:0]       shift,
    output logic [1:0]       alu_op,
    output logic [WIDTH-1:0] sximm8,
    output logic [WIDTH-1:0] sximm5,
    output logic [RN_W-1:0]  rnum,
    output logic             legal
);

    logic [RN_W-1:0] rn, rd, rm;

    assign opcode = ir[15:13];
    assign op     = ir[12:11];
    assign rn     = ir[8 +: RN_W];
    assign rd     = ir[5 +: RN_W];
    assign shift  = ir[4:3];
    assign rm     = ir[0 +: RN_W];
    assign alu_op = ir[12:11];

    assign sximm8 = {{(WIDTH-8){ir[7]}}, ir[7:0]};
    assign sximm5 = {{(WIDTH-5){ir[4]}}, ir[4:0]};

    assign legal = is_legal(opcode, op);

    always_comb begin
        rnum = rn;
        case (nsel)
            NSEL_RN: rnum = rn;
            NSEL_RD: rnum = rd;
            NSEL_RM: rnum = rm;
            default: rnum = rn;
        endcase
    end

endmodule

// File: rtl/cpu_controller.sv
// Instruction register plus multi-cycle Moore sequencer driving the register/ALU datapath.
module cpu_controller
    import cpu_pkg::*;
#(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned RN_W  = 3
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] in,
    input  logic             load,
    input  logic             s,
    output logic             w,
    output logic             illegal,
    output logic             write,
    output logic             loada,
    output logic             loadb,
    output logic             loadc,
    output logic             loads,
    output logic             asel,
    output logic             bsel,
    output logic [1:0]       vsel,
    output logic [RN_W-1:0]  readnum,
    output logic [RN_W-1:0]  writenum,
    output logic [1:0]       shift,
    output logic [1:0]       ALUop,
    output logic [WIDTH-1:0] sximm8,
    output logic [WIDTH-1:0] sximm5
);

    state_e           state_q;
    logic [WIDTH-1:0] ir_q;
    nsel_e            nsel;

    logic [2:0]      opcode;
    logic [1:0]      op, dec_shift, dec_alu_op;
    logic [RN_W-1:0] rnum;
    logic            legal;

    instr_decoder #(
        .WIDTH(WIDTH),
        .RN_W (RN_W)
    ) u_decoder (
        .ir    (ir_q),
        .nsel  (nsel),
        .opcode(opcode),
        .op    (op),
        .shift (dec_shift),
        .alu_op(dec_alu_op),
        .sximm8(sximm8),
        .sximm5(sximm5),
        .rnum  (rnum),
        .legal (legal)
    );

    logic is_mov_imm, is_mov_reg, is_cmp, is_mvn;
    assign is_mov_imm = (opcode == OPC_MOV) && (op == OP_MOV_IMM);
    assign is_mov_reg = (opcode == OPC_MOV) && (op == OP_MOV_REG);
    assign is_cmp     = (opcode == OPC_ALU) && (op == OP_CMP);
    assign is_mvn     = (opcode == OPC_ALU) && (op == OP_MVN);

    // IR and state update on the same edge, so load+s in WAIT decodes the new word.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= StWait;
            ir_q    <= '0;
        end else begin
            if (state_q == StWait && load) ir_q <= in;
            case (state_q)
                StWait:   if (s) state_q <= StDecode;
                StDecode: begin
                    if (!legal)                   state_q <= StWait;
                    else if (is_mov_imm)          state_q <= StWrImm;
                    else if (is_mov_reg || is_mvn) state_q <= StGetB;
                    else                          state_q <= StGetA;
                end
                StWrImm:  state_q <= StWait;
                StGetA:   state_q <= StGetB;
                StGetB:   state_q <= StAlu;
                StAlu:    state_q <= is_cmp ? StWait : StWrReg;
                StWrReg:  state_q <= StWait;
                default:  state_q <= StWait;
            endcase
        end
    end

    always_comb begin
        w       = 1'b0;
        illegal = 1'b0;
        write   = 1'b0;
        loada   = 1'b0;
        loadb   = 1'b0;
        loadc   = 1'b0;
        loads   = 1'b0;
        asel    = 1'b0;
        bsel    = 1'b0;
        vsel    = VSEL_C;
        nsel    = NSEL_RN;
        shift   = 2'b00;
        ALUop   = 2'b00;
        case (state_q)
            StWait:   w = 1'b1;
            StDecode: illegal = !legal;
            StWrImm: begin
                nsel  = NSEL_RN;
                vsel  = VSEL_IMM;
                write = 1'b1;
            end
            StGetA: begin
                nsel  = NSEL_RN;
                loada = 1'b1;
            end
            StGetB: begin
                nsel  = NSEL_RM;
                loadb = 1'b1;
            end
            StAlu: begin
                shift = dec_shift;
                // MOV reg passes B through the adder with A forced to zero.
                ALUop = is_mov_reg ? OP_ADD : dec_alu_op;
                asel  = is_mov_reg;
                loads = is_cmp;
                loadc = !is_cmp;
            end
            StWrReg: begin
                nsel  = NSEL_RD;
                vsel  = VSEL_C;
                write = 1'b1;
            end
            default: ;
        endcase
    end

    assign readnum  = rnum;
    assign writenum = rnum;

endmodule

// File: tb/tb_cpu_controller.sv
// Self-checking bench: table of instructions, per-cycle scoreboard from a reference model.
module tb_cpu_controller;

    logic        clk = 1'b0;
    logic        reset_n, load, s;
    logic [15:0] in;
    logic        w, illegal, write, loada, loadb, loadc, loads, asel, bsel;
    logic [1:0]  vsel, shift, ALUop;
    logic [2:0]  readnum, writenum;
    logic [15:0] sximm8, sximm5;

    cpu_controller #(.WIDTH(16), .RN_W(3)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .in      (in),
        .load    (load),
        .s       (s),
        .w       (w),
        .illegal (illegal),
        .write   (write),
        .loada   (loada),
        .loadb   (loadb),
        .loadc   (loadc),
        .loads   (loads),
        .asel    (asel),
        .bsel    (bsel),
        .vsel    (vsel),
        .readnum (readnum),
        .writenum(writenum),
        .shift   (shift),
        .ALUop   (ALUop),
        .sximm8  (sximm8),
        .sximm5  (sximm5)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       w, illegal, write, loada, loadb, loadc, loads, asel, bsel;
        logic [1:0] vsel;
        logic [2:0] readnum, writenum;
        logic [1:0] shift, alu_op;
    } obs_t;

    typedef struct {
        logic [15:0] instr;
        int          lat;
        int          writes;
        logic [15:0] sx8;
        logic [15:0] sx5;
    } vec_t;

    obs_t        exp_q[$];
    int          checks   = 0;
    int          failures = 0;
    logic [15:0] cur_ir;

    function automatic obs_t actual();
        obs_t a;
        a.w = w; a.illegal = illegal; a.write = write; a.loada = loada; a.loadb = loadb;
        a.loadc = loadc; a.loads = loads; a.asel = asel; a.bsel = bsel; a.vsel = vsel;
        a.readnum = readnum; a.writenum = writenum; a.shift = shift; a.alu_op = ALUop;
        return a;
    endfunction

    function automatic obs_t idle_obs();
        obs_t o = '0;
        o.w = 1'b1;
        return o;
    endfunction

    task automatic check_obs(input string name, input obs_t e);
        obs_t a = actual();
        // Register index only matters when a register-file port is in use.
        if (!(e.write || e.loada || e.loadb)) begin
            a.readnum = '0; a.writenum = '0; e.readnum = '0; e.writenum = '0;
        end
        checks++;
        if (a !== e) begin
            failures++;
            $display("FAIL %s: outputs got %h expected %h", name, a, e);
        end
    endtask

    task automatic check_val(input string name, input logic [31:0] a, input logic [31:0] e);
        checks++;
        if (a !== e) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, a, e);
        end
    endtask

    // Reference sequence of per-cycle outputs from DECODE back to WAIT.
    task automatic push_model(input logic [15:0] ir);
        logic [2:0] opc, rn, rd, rm;
        logic [1:0] op, sh;
        logic       mov_imm, mov_reg, alu, cmp, mvn;
        obs_t       o;
        opc = ir[15:13]; op = ir[12:11]; rn = ir[10:8]; rd = ir[7:5]; sh = ir[4:3]; rm = ir[2:0];
        mov_imm = (opc == 3'b110) && (op == 2'b10);
        mov_reg = (opc == 3'b110) && (op == 2'b00);
        alu     = (opc == 3'b101);
        cmp     = alu && (op == 2'b01);
        mvn     = alu && (op == 2'b11);
        o = '0;
        if (!(mov_imm || mov_reg || alu)) begin
            o.illegal = 1'b1;
            exp_q.push_back(o);
            exp_q.push_back(idle_obs());
            return;
        end
        exp_q.push_back(o);
        if (mov_imm) begin
            o = '0; o.write = 1'b1; o.vsel = 2'b10; o.readnum = rn; o.writenum = rn;
            exp_q.push_back(o);
        end else begin
            if (!(mov_reg || mvn)) begin
                o = '0; o.loada = 1'b1; o.readnum = rn; o.writenum = rn;
                exp_q.push_back(o);
            end
            o = '0; o.loadb = 1'b1; o.readnum = rm; o.writenum = rm;
            exp_q.push_back(o);
            o = '0; o.shift = sh; o.alu_op = mov_reg ? 2'b00 : op; o.asel = mov_reg;
            if (cmp) o.loads = 1'b1;
            else     o.loadc = 1'b1;
            exp_q.push_back(o);
            if (!cmp) begin
                o = '0; o.write = 1'b1; o.vsel = 2'b00; o.readnum = rd; o.writenum = rd;
                exp_q.push_back(o);
            end
        end
        exp_q.push_back(idle_obs());
    endtask

    // Called at a negedge with the DUT in WAIT; returns at the negedge where WAIT is back.
    task automatic exec(input string name, input logic [15:0] instr, input logic do_load,
                        input logic keep_s, input logic mid_load, input logic [15:0] mid_word,
                        output int lat, output int writes);
        int   cyc;
        obs_t e;
        if (do_load) cur_ir = instr;
        exp_q.delete();
        push_model(cur_ir);
        in = instr; load = do_load; s = 1'b1;
        lat = 0; writes = 0; cyc = 0;
        while (exp_q.size() > 0) begin
            @(negedge clk);
            cyc++;
            if (!keep_s) s = 1'b0;
            load = mid_load;
            if (mid_load) in = mid_word;
            e = exp_q.pop_front();
            check_obs(name, e);
            if (write === 1'b1) writes++;
            if (w === 1'b1 && lat == 0) lat = cyc;
        end
    endtask

    vec_t vecs[10];

    initial begin
        int lat, wr;
        obs_t e;
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int lat, wr;
        obs_t e;

        vecs[0] = '{16'hD007, 3, 1, 16'h0007, 16'h0007};  // MOV R0,#7
        vecs[1] = '{16'hD0F9, 3, 1, 16'hFFF9, 16'hFFF9};  // MOV R0,#-7
        vecs[2] = '{16'hA148, 6, 1, 16'h0048, 16'h0008};  // ADD R2,R1,R0 LSL#1
        vecs[3] = '{16'hA900, 5, 0, 16'h0000, 16'h0000};  // CMP R1,R0
        vecs[4] = '{16'hC020, 5, 1, 16'h0020, 16'h0000};  // MOV R1,R0
        vecs[5] = '{16'hB860, 5, 1, 16'h0060, 16'h0000};  // MVN R3,R0
        vecs[6] = '{16'hE000, 2, 0, 16'h0000, 16'h0000};  // illegal opcode
        vecs[7] = '{16'hB3F5, 6, 1, 16'hFFF5, 16'hFFF5};  // AND R7,R3,R5 LSR
        vecs[8] = '{16'hD800, 2, 0, 16'h0000, 16'h0000};  // opcode 110 op 11
        vecs[9] = '{16'h0000, 2, 0, 16'h0000, 16'h0000};

        // Reset held two cycles with s and load active.
        reset_n = 1'b0; s = 1'b1; load = 1'b1; in = 16'hD007;
        @(negedge clk);
        check_obs("reset_cycle1", idle_obs());
        @(negedge clk);
        check_obs("reset_cycle2", idle_obs());
        check_val("reset_ir_sximm8", 32'(sximm8), 32'h0);
        reset_n = 1'b1; load = 1'b0; s = 1'b1; cur_ir = 16'h0000;
        @(negedge clk);
        e = '0; e.illegal = 1'b1;
        check_obs("post_reset_decode", e);
        s = 1'b0;
        @(negedge clk);
        check_obs("post_reset_wait", idle_obs());

        foreach (vecs[i]) begin
            exec($sformatf("vec%0d_%h", i, vecs[i].instr), vecs[i].instr, 1'b1, 1'b0, 1'b0,
                 16'h0, lat, wr);
            check_val($sformatf("vec%0d_latency", i), 32'(lat), 32'(vecs[i].lat));
            check_val($sformatf("vec%0d_writes", i), 32'(wr), 32'(vecs[i].writes));
            check_val($sformatf("vec%0d_sximm8", i), 32'(sximm8), 32'(vecs[i].sx8));
            check_val($sformatf("vec%0d_sximm5", i), 32'(sximm5), 32'(vecs[i].sx5));
        end
        s = 1'b0;

        // s held high: second run re-executes the unchanged IR.
        exec("hold_s_first", 16'hD305, 1'b1, 1'b1, 1'b0, 16'h0, lat, wr);
        check_val("hold_s_first_writes", 32'(wr), 32'd1);
        exec("hold_s_again", 16'h0000, 1'b0, 1'b1, 1'b0, 16'h0, lat, wr);
        check_val("hold_s_again_writes", 32'(wr), 32'd1);
        check_val("hold_s_again_ir", 32'(sximm8), 32'h0005);
        s = 1'b0;

        // load asserted throughout an ADD must not disturb IR.
        exec("mid_load", 16'hA148, 1'b1, 1'b0, 1'b1, 16'hD102, lat, wr);
        check_val("mid_load_ir", 32'(sximm8), 32'h0048);
        load = 1'b0;

        // Reset arriving in GET_B aborts without a write.
        in = 16'hA148; load = 1'b1; s = 1'b1; cur_ir = 16'hA148;
        @(negedge clk);
        load = 1'b0; s = 1'b0;
        check_obs("rst_mid_decode", '0);
        @(negedge clk);
        @(negedge clk);
        e = '0; e.loadb = 1'b1;
        check_obs("rst_mid_getb", e);
        reset_n = 1'b0;
        @(negedge clk);
        check_obs("rst_mid_wait", idle_obs());
        reset_n = 1'b1;
        @(negedge clk);
        check_obs("rst_mid_stays_wait", idle_obs());
        check_val("rst_mid_ir_cleared", 32'(sximm8), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/cpu_controller.md
Name: cpu_controller

Overview:
- Sequencer for the team's 16-bit register/ALU datapath.
- Holds the instruction register (IR), decodes the current instruction, and runs a multi-cycle Moore FSM.
- The FSM drives every datapath control: register-file read/write, A/B/C/status loads, mux selects, shift and ALUop.
- Sits between the instruction source (in/load/s) and the datapath; w tells the source when the next instruction may start.

Parameters:
- WIDTH, 16, instruction and datapath word width.
- RN_W, 3, register index width.

Ports:
- clk  input  1  system clock, all state on rising edge
- reset_n  input  1  synchronous active-low reset
- in  input  16  instruction word
- load  input  1  capture in into IR (honoured only in WAIT)
- s  input  1  start execution of IR (sampled only in WAIT)
- w  output  1  high only in WAIT
- illegal  output  1  one-cycle pulse on unsupported opcode
- write, loada, loadb, loadc, loads, asel, bsel  output  1 each  datapath strobes/selects
- vsel  output  2  00=C, 01=PC, 10=sximm8, 11=m_data
- readnum, writenum  output  3  register indices
- shift, ALUop  output  2 each  taken from IR[4:3], IR[12:11]
- sximm8, sximm5  output  16 each  sign-extended IR[7:0], IR[4:0]

Behaviour:
- IR decode fields: opcode=IR[15:13], op=IR[12:11], Rn=IR[10:8], Rd=IR[7:5], sh=IR[4:3], Rm=IR[2:0].
- Supported instructions:
  - MOV Rn,#im8: opcode 110, op 10.
  - MOV Rd,Rm{,sh}: opcode 110, op 00.
  - ADD / CMP / AND / MVN: opcode 101, op 00 / 01 / 10 / 11.
  - Every other combination is illegal.
- Reset (reset_n=0 at clk edge): state=WAIT, IR=0, w=1, illegal=0, all strobes=0, vsel=00. Reset overrides any state, including mid-instruction; no register write occurs on the reset cycle.
- IR: loads in when load=1 and state==WAIT; load is ignored in any other state.
- load=1 and s=1 in the same WAIT cycle: IR captures in AND the FSM moves to DECODE, so the new word executes.
- Outputs are Moore, a function of state and IR only. All strobes default to 0.
- readnum/writenum come from an nsel mux over Rn/Rd/Rm, so both ports carry the same index.
- sximm8/sximm5 are continuous sign extensions of IR.
- bsel=0 always.
- FSM states and transitions:
  - WAIT: w=1. s=1 -> DECODE, else stay.
  - DECODE: no strobes.
    - MOV imm -> WR_IMM.
    - MOV reg / MVN -> GET_B.
    - ADD / CMP / AND -> GET_A.
    - illegal -> WAIT, with illegal=1 for this cycle.
  - WR_IMM: nsel=Rn, vsel=10, write=1 -> WAIT.
  - GET_A: nsel=Rn, loada=1 -> GET_B.
  - GET_B: nsel=Rm, loadb=1 -> ALU.
  - ALU: shift=sh, ALUop=op (MOV reg forces ALUop=00 with asel=1).
    - CMP: loads=1, loadc=0 -> WAIT.
    - all others: loadc=1, loads=0 -> WR_REG.
  - WR_REG: nsel=Rd, vsel=00, write=1 -> WAIT.
- Latency from s sampled (cycle 0) to w high again:
  - MOV imm: 3 cycles.
  - MOV reg / MVN: 5 cycles.
  - ADD / AND: 6 cycles.
  - CMP: 5 cycles.
  - illegal: 2 cycles.
- s held high continuously: a new instruction starts on each WAIT cycle, and the IR is re-executed if it was not reloaded.
- write is asserted in exactly one cycle per writing instruction, and never for CMP or illegal.

Decomposition:
- Package cpu_pkg:
  - state enum (WAIT, DECODE, WR_IMM, GET_A, GET_B, ALU, WR_REG)
  - opcode/op constants
  - nsel encoding (NSEL_RN, NSEL_RD, NSEL_RM)
  - vsel constants
- Sub-module instr_decoder: purely combinational. Takes IR and nsel; produces opcode, op, shift, ALUop, sximm8, sximm5, readnum/writenum and the legal flag.
- FSM and IR live in cpu_controller.

Test Plan:
- Reset check: reset_n=0 for 2 cycles with s=1 -> w=1, all strobes 0, IR=0. Release -> FSM enters DECODE on the next s cycle.
- MOV imm: load=1, in=0xD007, s=1 in the same cycle -> 3rd cycle shows write=1, vsel=10, writenum=0, sximm8=0x0007; w=1 on the following cycle. Also in=0xD0F9 -> sximm8=0xFFF9.
- ADD with shift: in=0xA148 (ADD R2,R1,R0 LSL#1), s=1 -> strobe sequence:
  - loada with readnum=1
  - loadb with readnum=0
  - loadc with shift=01, ALUop=00
  - write with writenum=2, vsel=00
  - w=1 on the 6th cycle.
- CMP: in=0xA900, s=1 -> ALU cycle has loads=1, loadc=0. write never asserts. w=1 on the 5th cycle.
- MOV reg / MVN: in=0xC020 -> GET_B readnum=0, ALU asel=1 ALUop=00, write writenum=1. in=0xB860 -> ALUop=11, write writenum=3.
- Illegal and boundaries:
  - in=0xE000, s=1 -> illegal pulses for 1 cycle, no strobes, back to WAIT.
  - load=1 with in=0xD102 mid-ADD -> IR unchanged.
  - reset_n=0 during GET_B -> next cycle in WAIT, no write.
